// File: rtl/pulse_seq_pkg.sv
// -----------------------------------------------------------------------------
// pulse_seq_pkg
// Shared timing for the read/write pulse sequence. The pulse generator and the
// receive-side sampler both import this package so their window timing comes
// from one place.
//   PULSE_WIDTH_READ  : default read pulse width in clk cycles
//   PULSE_WIDTH_WRITE : default write pulse width in clk cycles
//   PULSE_LOW_WIDTH   : default zero-level gap after every pulse
//   ZERO_CODE         : generator output code for the zero level
//   sampler_state_e   : pulse_read_sampler FSM states
// -----------------------------------------------------------------------------
package pulse_seq_pkg;

  localparam int unsigned PULSE_WIDTH_READ  = 32'd200000;
  localparam int unsigned PULSE_WIDTH_WRITE = 32'd100000;
  localparam int unsigned PULSE_LOW_WIDTH   = 32'd50000;
  localparam int unsigned ZERO_CODE         = 32'd128;

  typedef enum logic [2:0] {
    SMP_IDLE    = 3'd0,
    SMP_SETTLE  = 3'd1,
    SMP_ACQ     = 3'd2,
    SMP_PUBLISH = 3'd3,
    SMP_GAP     = 3'd4
  } sampler_state_e;

endpackage

// File: rtl/pulse_read_sampler_accum.sv
// -----------------------------------------------------------------------------
// window_accumulator
// Per-window sample accumulator: running sum, sample count and, when
// PULSE_SAMPLER_MINMAX_EN is defined, running minimum/maximum.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (wins over add)
//   add        : accumulate data this cycle
//   data       : sample to accumulate
//   avg        : sum truncated-divided by 2^AVG_LOG2
//   full       : 2^AVG_LOG2 samples have been collected
//   done       : the sample added this cycle completes the burst
//   min_val    : window minimum (0 without PULSE_SAMPLER_MINMAX_EN)
//   max_val    : window maximum (0 without PULSE_SAMPLER_MINMAX_EN)
// -----------------------------------------------------------------------------
module window_accumulator #(
  parameter int unsigned ADC_W    = 32'd12,
  parameter int unsigned AVG_LOG2 = 32'd10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add,
  input  logic [ADC_W-1:0] data,
  output logic [ADC_W-1:0] avg,
  output logic             full,
  output logic             done,
  output logic [ADC_W-1:0] min_val,
  output logic [ADC_W-1:0] max_val
);

  localparam int unsigned SUM_W = ADC_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] CNT_FULL = {1'b1, {AVG_LOG2{1'b0}}};
  localparam logic [AVG_LOG2:0] CNT_LAST = CNT_FULL - {{AVG_LOG2{1'b0}}, 1'b1};

  logic [SUM_W-1:0]  sum_r;
  logic [AVG_LOG2:0] cnt_r;

  // Running sum and sample count for the current window.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r <= {SUM_W{1'b0}};
      cnt_r <= {(AVG_LOG2+1){1'b0}};
    end else if (clear) begin
      sum_r <= {SUM_W{1'b0}};
      cnt_r <= {(AVG_LOG2+1){1'b0}};
    end else if (add) begin
      sum_r <= sum_r + {{AVG_LOG2{1'b0}}, data};
      cnt_r <= cnt_r + {{AVG_LOG2{1'b0}}, 1'b1};
    end
  end

  assign avg  = sum_r[SUM_W-1 -: ADC_W];
  assign full = (cnt_r == CNT_FULL);
  // The completing sample is already counted by the time the result is loaded.
  assign done = add && (cnt_r == CNT_LAST);

`ifdef PULSE_SAMPLER_MINMAX_EN
  logic [ADC_W-1:0] min_r;
  logic [ADC_W-1:0] max_r;

  // Running extremes; the first sample of a window seeds both.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_r <= {ADC_W{1'b0}};
      max_r <= {ADC_W{1'b0}};
    end else if (clear) begin
      min_r <= {ADC_W{1'b0}};
      max_r <= {ADC_W{1'b0}};
    end else if (add) begin
      if ((cnt_r == {(AVG_LOG2+1){1'b0}}) || (data < min_r)) min_r <= data;
      if ((cnt_r == {(AVG_LOG2+1){1'b0}}) || (data > max_r)) max_r <= data;
    end
  end

  assign min_val = min_r;
  assign max_val = max_r;
`else
  assign min_val = {ADC_W{1'b0}};
  assign max_val = {ADC_W{1'b0}};
`endif

endmodule

// File: rtl/pulse_read_sampler.sv
// -----------------------------------------------------------------------------
// pulse_read_sampler
// Receive-side companion to the pulse generator. Follows the four-read /
// three-write sequence from the shared start strobe, averages a settled burst
// of ADC samples in each read window and offers one result per window on a
// valid/ready interface.
//   clk, reset          : clock, synchronous active-high reset
//   start               : sequence start / restart strobe
//   adc_valid, adc_data : ADC sample stream
//   res_valid/res_ready : result handshake
//   res_data            : averaged sample (truncating)
//   res_index           : read window number 0..3
//   res_short           : window closed before the burst was complete
//   res_min, res_max    : window extremes (0 unless PULSE_SAMPLER_MINMAX_EN)
//   busy                : sequence time has not yet passed the sequence end
//   overrun             : sticky, an unaccepted result was overwritten
// Optional feature macro: PULSE_SAMPLER_MINMAX_EN.
// -----------------------------------------------------------------------------
module pulse_read_sampler
  import pulse_seq_pkg::*;
#(
  parameter int unsigned WIDTH_READ  = PULSE_WIDTH_READ,
  parameter int unsigned WIDTH_WRITE = PULSE_WIDTH_WRITE,
  parameter int unsigned LOW_WIDTH   = PULSE_LOW_WIDTH,
  parameter int unsigned SETTLE      = 32'd1000,
  parameter int unsigned AVG_LOG2    = 32'd10,
  parameter int unsigned ADC_W       = 32'd12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ADC_W-1:0] res_data,
  output logic [1:0]       res_index,
  output logic             res_short,
  output logic [ADC_W-1:0] res_min,
  output logic [ADC_W-1:0] res_max,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned PR      = WIDTH_READ + LOW_WIDTH;
  localparam int unsigned PW      = WIDTH_WRITE + LOW_WIDTH;
  localparam int unsigned P       = PR + PW;
  localparam int unsigned SEQ_END = 32'd3 * P + PR;
  localparam int unsigned T_W     = $clog2(SEQ_END + 32'd2);

  localparam logic [T_W-1:0] P_T      = T_W'(P);
  localparam logic [T_W-1:0] SETTLE_T = T_W'(SETTLE);
  localparam logic [T_W-1:0] WR_T     = T_W'(WIDTH_READ);
  localparam logic [T_W-1:0] END_T    = T_W'(SEQ_END);

  sampler_state_e   state_r;
  logic [T_W-1:0]   t_r;
  logic [T_W-1:0]   base_r;      // k*P for the current window
  logic [1:0]       k_r;
  logic             settle_hit_s;
  logic             win_end_s;
  logic             gap_hit_s;
  logic             publish_s;
  logic             acc_clear_s;
  logic             acc_add_s;
  logic             acc_done_s;
  logic             acc_full_s;
  logic [ADC_W-1:0] acc_avg_s;
  logic [ADC_W-1:0] acc_min_s;
  logic [ADC_W-1:0] acc_max_s;

  window_accumulator #(
    .ADC_W    (ADC_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (acc_clear_s),
    .add     (acc_add_s),
    .data    (adc_data),
    .avg     (acc_avg_s),
    .full    (acc_full_s),
    .done    (acc_done_s),
    .min_val (acc_min_s),
    .max_val (acc_max_s)
  );

  // Window boundary decode and accumulator controls.
  always_comb begin
    settle_hit_s = (t_r >= base_r + SETTLE_T);
    win_end_s    = (t_r >= base_r + WR_T);
    gap_hit_s    = (t_r >= base_r);
    acc_add_s    = (state_r == SMP_ACQ) && adc_valid;
    // A restart discards the partial window, including one about to publish.
    acc_clear_s  = start || (state_r == SMP_PUBLISH);
    publish_s    = (state_r == SMP_PUBLISH) && !start;
  end

  // Sequence time: zero the cycle after start, saturates one past the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_r  <= {T_W{1'b0}};
      busy <= 1'b0;
    end else if (start) begin
      t_r  <= {T_W{1'b0}};
      busy <= 1'b1;
    end else if (busy) begin
      t_r <= t_r + T_W'(1'b1);
      if (t_r == END_T) busy <= 1'b0;
    end
  end

  // Window FSM plus the registered result interface.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= SMP_IDLE;
      k_r       <= 2'd0;
      base_r    <= {T_W{1'b0}};
      res_valid <= 1'b0;
      res_data  <= {ADC_W{1'b0}};
      res_index <= 2'd0;
      res_short <= 1'b0;
      res_min   <= {ADC_W{1'b0}};
      res_max   <= {ADC_W{1'b0}};
      overrun   <= 1'b0;
    end else begin
      if (start) begin
        state_r <= SMP_SETTLE;
        k_r     <= 2'd0;
        base_r  <= {T_W{1'b0}};
      end else begin
        case (state_r)
          SMP_IDLE:    state_r <= SMP_IDLE;
          SMP_SETTLE:  if (settle_hit_s) state_r <= SMP_ACQ;
          SMP_ACQ:     if (acc_done_s || win_end_s) state_r <= SMP_PUBLISH;
          SMP_PUBLISH: begin
            k_r     <= k_r + 2'd1;
            base_r  <= base_r + P_T;
            state_r <= (k_r == 2'd3) ? SMP_IDLE : SMP_GAP;
          end
          SMP_GAP:     if (gap_hit_s) state_r <= SMP_SETTLE;
          default:     state_r <= SMP_IDLE;
        endcase
      end

      // A publish always replaces the held result; a same-cycle handshake
      // means the old one was taken, so that is not an overrun.
      if (publish_s) begin
        res_valid <= 1'b1;
        res_data  <= acc_avg_s;
        res_index <= k_r;
        res_short <= !acc_full_s;
        res_min   <= acc_min_s;
        res_max   <= acc_max_s;
        if (res_valid && !res_ready) overrun <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_read_sampler.sv
// -----------------------------------------------------------------------------
// tb_pulse_read_sampler
// Directed bench for pulse_read_sampler with WIDTH_READ=40, WIDTH_WRITE=20,
// LOW_WIDTH=10, SETTLE=4, AVG_LOG2=3 (P=80, sequence end t=290). Accepted
// results are collected by a negedge monitor and compared with hand-computed
// values. Optional PULSE_SAMPLER_MINMAX_EN section checks the extremes.
// -----------------------------------------------------------------------------
module tb_pulse_read_sampler;

  localparam int SEQ_END = 290;
  localparam int NLOG    = 400;

  logic        clk = 1'b0;
  logic        reset, start, adc_valid, res_ready;
  logic [11:0] adc_data;
  logic        res_valid, res_short, busy, overrun;
  logic [11:0] res_data, res_min, res_max;
  logic [1:0]  res_index;

  int n_checks = 0;
  int n_errors = 0;

  int busy_log [0:NLOG-1];
  int valid_log[0:NLOG-1];
  int idx_log  [0:NLOG-1];
  int data_log [0:NLOG-1];
  int ovr_log  [0:NLOG-1];

  int r_data[0:7], r_idx[0:7], r_short[0:7], r_min[0:7], r_max[0:7];
  int n_res;
  bit cap;
  int exp_mm;

  pulse_read_sampler #(
    .WIDTH_READ(40), .WIDTH_WRITE(20), .LOW_WIDTH(10),
    .SETTLE(4), .AVG_LOG2(3), .ADC_W(12)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_index(res_index), .res_short(res_short),
    .res_min(res_min), .res_max(res_max),
    .busy(busy), .overrun(overrun)
  );

  always #10 clk = ~clk;

  // Record every accepted result.
  always @(negedge clk) begin
    if (cap && res_valid && res_ready) begin
      if (n_res < 8) begin
        r_data[n_res]  <= int'(res_data);
        r_idx[n_res]   <= int'(res_index);
        r_short[n_res] <= int'(res_short);
        r_min[n_res]   <= int'(res_min);
        r_max[n_res]   <= int'(res_max);
      end
      n_res <= n_res + 1;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; adc_valid = 1'b0; res_ready = 1'b0;
    adc_data = 12'h000;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic clear_results();
    for (int i = 0; i < 8; i++) begin
      r_data[i] = -1; r_idx[i] = -1; r_short[i] = -1; r_min[i] = -1; r_max[i] = -1;
    end
    n_res = 0;
  endtask

  // Start a sequence and drive it for ncycles values of t. Optional restart
  // at t == restart_at; res_ready is held low until that restart happened.
  task automatic run_seq(input int mode, input int ready_from,
                         input int restart_at, input int ncycles);
    int          t;
    bit          restarted;
    logic        v;
    logic [11:0] d;
    clear_results();
    cap = 1'b1;
    adc_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    restarted = 1'b0;
    while (t < ncycles) begin
      busy_log[t]  = int'(busy);
      valid_log[t] = int'(res_valid);
      idx_log[t]   = int'(res_index);
      data_log[t]  = int'(res_data);
      ovr_log[t]   = int'(overrun);
      case (mode)
        0: begin v = 1'b1; d = 12'h800; end
        1: begin v = 1'b1; d = 12'(t % 80) - 12'd4; end
        2: begin v = ((t % 8) == 0); d = 12'(t); end
        3: begin v = 1'b1; d = 12'((t / 80 + 1) * 256); end
        5: begin v = 1'b1; d = (t == 166) ? 12'h010 : ((t == 168) ? 12'hFF0 : 12'h800); end
        default: begin v = 1'b0; d = 12'h000; end
      endcase
      adc_valid = v;
      adc_data  = d;
      res_ready = (t >= ready_from) && ((restart_at < 0) || restarted);
      if (!restarted && (t == restart_at)) start = 1'b1;
      step();
      if (start) begin
        start = 1'b0;
        restarted = 1'b1;
        t = 0;
      end else begin
        t++;
      end
    end
    adc_valid = 1'b0;
    res_ready = 1'b0;
    step();
    step();
    cap = 1'b0;
  endtask

  initial begin
    int sparse_exp[0:3];
    int rst_exp_idx[0:4];
    int rst_exp_data[0:4];
    int seen;
    sparse_exp = '{15, 65, 115, 165};
    rst_exp_idx  = '{0, 0, 1, 2, 3};
    rst_exp_data = '{15, 15, 65, 115, 165};
`ifdef PULSE_SAMPLER_MINMAX_EN
    exp_mm = 'h800;
`else
    exp_mm = 0;
`endif
    cap = 1'b0;
    clear_results();

    // Reset state
    do_reset();
    check_eq("rst_valid", int'(res_valid), 0);
    check_eq("rst_data", int'(res_data), 0);
    check_eq("rst_index", int'(res_index), 0);
    check_eq("rst_short", int'(res_short), 0);
    check_eq("rst_min", int'(res_min), 0);
    check_eq("rst_max", int'(res_max), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_overrun", int'(overrun), 0);

    // Constant 0x800, sample every cycle, always ready
    run_seq(0, 0, -1, SEQ_END + 3);
    check_eq("const_nres", n_res, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("const_idx%0d", i), r_idx[i], i);
      check_eq($sformatf("const_data%0d", i), r_data[i], 'h800);
      check_eq($sformatf("const_short%0d", i), r_short[i], 0);
      check_eq($sformatf("const_min%0d", i), r_min[i], exp_mm);
      check_eq($sformatf("const_max%0d", i), r_max[i], exp_mm);
    end
    check_eq("busy_t0", busy_log[0], 1);
    check_eq("busy_tend", busy_log[SEQ_END], 1);
    check_eq("busy_tend1", busy_log[SEQ_END + 1], 0);
    check_eq("valid_t13", valid_log[13], 0);
    check_eq("valid_t14", valid_log[14], 1);
    check_eq("valid_t15", valid_log[15], 0);
    check_eq("const_overrun", int'(overrun), 0);

    // Ramp: samples 1..8 in each window -> 36 >> 3 = 4
    do_reset();
    run_seq(1, 0, -1, SEQ_END + 3);
    check_eq("ramp_nres", n_res, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ramp_idx%0d", i), r_idx[i], i);
      check_eq($sformatf("ramp_data%0d", i), r_data[i], 4);
      check_eq($sformatf("ramp_short%0d", i), r_short[i], 0);
    end

    // Sparse: one sample per 8 cycles, data = t, 5 samples per window
    do_reset();
    run_seq(2, 0, -1, SEQ_END + 3);
    check_eq("sparse_nres", n_res, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("sparse_idx%0d", i), r_idx[i], i);
      check_eq($sformatf("sparse_data%0d", i), r_data[i], sparse_exp[i]);
      check_eq($sformatf("sparse_short%0d", i), r_short[i], 1);
    end

    // No samples at all
    do_reset();
    run_seq(4, 0, -1, SEQ_END + 3);
    check_eq("empty_nres", n_res, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("empty_data%0d", i), r_data[i], 0);
      check_eq($sformatf("empty_short%0d", i), r_short[i], 1);
    end

    // Overrun: consumer stalled across windows 0 and 1
    do_reset();
    run_seq(3, 150, -1, SEQ_END + 3);
    check_eq("ovr_t93", ovr_log[93], 0);
    check_eq("ovr_t94", ovr_log[94], 1);
    check_eq("ovr_valid149", valid_log[149], 1);
    check_eq("ovr_idx149", idx_log[149], 1);
    check_eq("ovr_data149", data_log[149], 'h200);
    check_eq("ovr_nres", n_res, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("ovr_idx%0d", i), r_idx[i], i + 1);
      check_eq($sformatf("ovr_data%0d", i), r_data[i], (i + 2) * 'h100);
    end
    check_eq("ovr_sticky", int'(overrun), 1);

    // Restart at t=100 with window 0 result still pending
    do_reset();
    run_seq(2, 10, 100, SEQ_END + 3);
    check_eq("rs_valid5", valid_log[5], 1);
    check_eq("rs_idx5", idx_log[5], 0);
    check_eq("rs_data5", data_log[5], 15);
    check_eq("rs_nres", n_res, 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rs_idx%0d", i), r_idx[i], rst_exp_idx[i]);
      check_eq($sformatf("rs_data%0d", i), r_data[i], rst_exp_data[i]);
    end
    check_eq("rs_overrun", int'(overrun), 0);

    // Reset in the middle of window 0 produces no result
    do_reset();
    run_seq(2, 0, -1, 30);
    do_reset();
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (res_valid || busy) seen++;
    end
    check_eq("abort_quiet", seen, 0);
    check_eq("abort_nres", n_res, 0);

`ifdef PULSE_SAMPLER_MINMAX_EN
    // Extremes injected into window 2
    do_reset();
    run_seq(5, 0, -1, SEQ_END + 3);
    check_eq("mm_nres", n_res, 4);
    check_eq("mm_min2", r_min[2], 'h010);
    check_eq("mm_max2", r_max[2], 'hFF0);
    check_eq("mm_data2", r_data[2], 'h800);
    check_eq("mm_min0", r_min[0], 'h800);
    check_eq("mm_max3", r_max[3], 'h800);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_read_sampler.md
# pulse_read_sampler

Receive-side companion to the pulse generator. It tracks the same four-read / three-write sequence timing from a shared start strobe and samples the external ADC during each read window. For each read window it averages a settled burst of samples and hands one result per window downstream over a valid/ready interface. It sits between the ADC capture interface and the measurement logger.

## Interface
Parameters:
- WIDTH_READ, 200000: read pulse width in clk cycles (4 ms at 20 ns).
- WIDTH_WRITE, 100000: write pulse width in cycles.
- LOW_WIDTH, 50000: zero-level gap after every pulse.
- SETTLE, 1000: cycles skipped at the start of each read window before sampling.
- AVG_LOG2, 10: averaging depth; 2^AVG_LOG2 samples per window.
- ADC_W, 12: ADC sample width.

Ports:
- clk, in, 1: system clock, 20 ns.
- reset, in, 1: synchronous, active-high.
- start, in, 1: one-cycle strobe, asserted in the same cycle the generator's trigger clears its counter.
- adc_valid, in, 1: adc_data is a new sample this cycle.
- adc_data, in, ADC_W: unsigned ADC code.
- res_valid, out, 1: result held.
- res_ready, in, 1: consumer accepts.
- res_data, out, ADC_W: averaged sample.
- res_index, out, 2: read window number, 0–3.
- res_short, out, 1: window closed before 2^AVG_LOG2 samples were collected.
- res_min, out, ADC_W: minimum sample in the window. Present only with MINMAX.
- res_max, out, ADC_W: maximum sample in the window. Present only with MINMAX.
- busy, out, 1: sequence in progress.
- overrun, out, 1: sticky; a result was overwritten before it was accepted.

## Operation
- Derived constants: PR = WIDTH_READ+LOW_WIDTH, PW = WIDTH_WRITE+LOW_WIDTH, P = PR+PW, END = 3P+PR.
- Sequence time t: set to 0 in the cycle after start, then increments by 1 each cycle. It stops counting once t passes END.
- Read window k (0–3) spans t = k·P … k·P+WIDTH_READ, inclusive.
- FSM states:
  - IDLE: start → SETTLE.
  - SETTLE: t = k·P+SETTLE → ACQ.
  - ACQ: accumulate each adc_valid sample into sum (width ADC_W+AVG_LOG2) and cnt. Exit when cnt = 2^AVG_LOG2 or t = k·P+WIDTH_READ, then go to PUBLISH.
  - PUBLISH: one cycle; load the output register, k++. If k was 3 → IDLE, otherwise → GAP.
  - GAP: t = k·P → SETTLE.
- Result values:
  - res_data = sum[ADC_W+AVG_LOG2-1:AVG_LOG2], i.e. truncating divide by 2^AVG_LOG2.
  - On a short window the result uses the same shift, so it is biased low, and res_short = 1.
  - If a window sees zero samples: res_data = 0, res_short = 1.
- Handshake: res_valid rises in PUBLISH and drops on the cycle after res_valid & res_ready. res_data, res_index and res_short are held stable while res_valid = 1.
- Overwrite: if PUBLISH occurs while res_valid = 1 and res_ready = 0, the new result replaces the old one and overrun is set. overrun is cleared only by reset.
- start while busy: restart. Clear t, k, sum and cnt, and go to SETTLE. A pending unaccepted result is kept.
- busy = 1 from the cycle after start until t > END.

## Timing
- Reset values: res_valid 0, res_data 0, res_index 0, res_short 0, res_min 0, res_max 0, busy 0, overrun 0. FSM in IDLE.
- Reset mid-sequence aborts immediately; no result is produced.
- A sample accepted in the exit cycle of ACQ is included in the result.
- res_valid appears 2 cycles after the accepting adc_valid: exit cycle, then PUBLISH, then registered output.
- Simultaneous res_ready handshake and PUBLISH in the same cycle: the new result loads and overrun is not set.
- Simultaneous start and PUBLISH: start wins; the partial result is discarded.

## Configuration
- PULSE_SAMPLER_MINMAX_EN defined: track the minimum and maximum sample over each ACQ and publish them with the result. Both reset to the first sample of the window.
- Not defined: no comparators are built; res_min and res_max are tied to 0.

## Structure
- Package pulse_seq_pkg holds:
  - the WIDTH_READ / WIDTH_WRITE / LOW_WIDTH defaults;
  - ZERO_CODE = 128;
  - the sampler FSM state enum.
- The pulse generator imports the same package so the two timings cannot drift.
- One sub-module, window_accumulator: holds sum, cnt and optional min/max, with clear/add/done controls.

## Test plan
Run with WIDTH_READ=40, WIDTH_WRITE=20, LOW_WIDTH=10, SETTLE=4, AVG_LOG2=3.
- Constant adc_data=0x800 with adc_valid every cycle, res_ready=1 → four results, index 0–3, data 0x800, res_short 0, busy drops at t=END+1.
- Ramp input: window 0 samples 1–8 → res_data 4 (sum 36 >> 3).
- adc_valid once every 8 cycles (5 samples per window) → res_short=1 and res_data = sum>>3.
- Hold res_ready=0 across two windows → overrun=1 and res_index=1 is held.
- Second start at t=100 → windows restart at index 0 and the earlier pending result is still presented first.
- With MINMAX enabled, inject 0x010 and 0xFF0 into window 2 → res_min=0x010, res_max=0xFF0.
